// File: rtl/result_window_accumulator.sv
// -----------------------------------------------------------------------------
// result_window_accumulator
//
// Purpose:
//   Consumes the 24-bit datapath result stream one word per valid/ready
//   handshake and reduces each window of COUNT words into a statistics record:
//   unsigned sum, minimum, maximum and running XOR. The record is presented on
//   registered outputs with its own valid/ready handshake. While a record is
//   waiting to be taken the input side is stalled (in_ready = 0).
//
// Parameters:
//   DATA_W  width of each incoming result word
//   COUNT   results per window, 1..65535
//   ACC_W   sum width, derived so that COUNT * (2^DATA_W - 1) never wraps
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   asynchronous, active-high reset
//   clear      in   synchronous abort of the partial window or held record
//   in_valid   in   in_data is valid this cycle
//   in_ready   out  block accepts in_data this cycle (comb from state + clear)
//   in_data    in   unsigned result word
//   out_valid  out  statistics record is valid (registered)
//   out_ready  in   downstream takes the record this cycle
//   out_sum    out  unsigned sum of the window samples
//   out_min    out  smallest sample in the window
//   out_max    out  largest sample in the window
//   out_xor    out  bitwise XOR of all window samples
// -----------------------------------------------------------------------------
module result_window_accumulator #(
  parameter  int DATA_W = 24,
  parameter  int COUNT  = 8,
  localparam int ACC_W  = DATA_W + $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_xor
);

  // Sample counter must hold 0..COUNT-1; sizing on COUNT+1 keeps it at least
  // one bit wide for COUNT = 1.
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [ACC_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_xor;

  logic [ACC_W-1:0]  r_out_sum;
  logic [DATA_W-1:0] r_out_min;
  logic [DATA_W-1:0] r_out_max;
  logic [DATA_W-1:0] r_out_xor;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_first;
  logic [ACC_W-1:0]  w_sum_nxt;
  logic [DATA_W-1:0] w_min_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [DATA_W-1:0] w_xor_nxt;

  // in_ready already folds in !clear, so an accept can never coincide with
  // an abort and clear wins without extra gating.
  assign w_accept = in_valid && w_in_ready;
  assign w_last   = w_accept && (r_count == LAST_IDX);
  assign w_first  = (r_count == '0);

  // Running values including the sample offered this cycle. The first sample
  // of a window seeds min/max so the reset value of 0 never leaks into min.
  assign w_sum_nxt = r_sum + {{(ACC_W - DATA_W){1'b0}}, in_data};
  assign w_xor_nxt = r_xor ^ in_data;
  assign w_min_nxt = (w_first || (in_data < r_min)) ? in_data : r_min;
  assign w_max_nxt = (w_first || (in_data > r_max)) ? in_data : r_max;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others, independent of the
  // order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block covers
  // every path, so no latch is inferred when a branch leaves it untouched.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_last)    w_state_nxt = ST_HOLD;
        ST_HOLD:  if (out_ready) w_state_nxt = ST_ACCUM;
        default:                 w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // out_valid is decoded straight from the state register, so it is glitch-free
  // and registered; in_ready additionally drops combinationally on clear.
  always_comb begin
    w_in_ready = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      ST_ACCUM: w_in_ready = !clear;
      ST_HOLD:  out_valid  = 1'b1;
      default: begin
        w_in_ready = 1'b0;
        out_valid  = 1'b0;
      end
    endcase
  end

  assign in_ready = w_in_ready;

  // ---------------------------------------------------------------------------
  // Window accumulators
  // ---------------------------------------------------------------------------
  // Accumulators are zeroed when a window completes (and on clear), so the
  // return from HOLD to ACCUM always starts from a clean window. Nothing can
  // be accepted while in HOLD, so they stay zero until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_xor   <= '0;
    end else if (clear || w_last) begin
      r_count <= '0;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_xor   <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
      r_sum   <= w_sum_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
      r_xor   <= w_xor_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output record
  // ---------------------------------------------------------------------------
  // Loaded only by the completing accept, so the record includes the final
  // sample and stays frozen through HOLD and afterwards. clear does not touch
  // these registers; only reset zeroes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sum <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
      r_out_xor <= '0;
    end else if (w_last) begin
      r_out_sum <= w_sum_nxt;
      r_out_min <= w_min_nxt;
      r_out_max <= w_max_nxt;
      r_out_xor <= w_xor_nxt;
    end
  end

  assign out_sum = r_out_sum;
  assign out_min = r_out_min;
  assign out_max = r_out_max;
  assign out_xor = r_out_xor;

endmodule

// File: tb/tb_result_window_accumulator.sv
// -----------------------------------------------------------------------------
// tb_result_window_accumulator
//
// Directed bench for result_window_accumulator with COUNT = 4. Stimulus
// pushes hand-computed expected records into a queue; an independent monitor
// pops and compares whenever a record is handshaken out. Inputs change 1 ns
// after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_result_window_accumulator;

  localparam int DATA_W = 24;
  localparam int COUNT  = 4;
  localparam int ACC_W  = DATA_W + $clog2(COUNT + 1);

  typedef struct {
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] min;
    logic [DATA_W-1:0] max;
    logic [DATA_W-1:0] xv;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_xor;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_popped = 0;

  result_window_accumulator #(.DATA_W(DATA_W), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_xor   (out_xor)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] s, input logic [DATA_W-1:0] mn,
                          input logic [DATA_W-1:0] mx, input logic [DATA_W-1:0] xv);
    rec_t r;
    r.sum = s; r.min = mn; r.max = mx; r.xv = xv;
    exp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until handshaken; returns at posedge+1 of
  // the accepting edge.
  task automatic send(input logic [DATA_W-1:0] d);
    bit accepted;
    in_valid = 1'b1;
    in_data  = d;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      step();
    end
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares each record taken downstream against the queue head.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          n_popped++;
          check("rec_sum", 32'(out_sum), 32'(r.sum));
          check("rec_min", 32'(out_min), 32'(r.min));
          check("rec_max", 32'(out_max), 32'(r.max));
          check("rec_xor", 32'(out_xor), 32'(r.xv));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    idle(2);
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_min",   32'(out_min),   32'd0);
    check("rst_out_max",   32'(out_max),   32'd0);
    check("rst_out_xor",   32'(out_xor),   32'd0);
    rst = 1'b0;
    idle(1);

    // 1: back-to-back 1..4, record visible one cycle after 4th accept
    push_exp(27'd10, 24'd1, 24'd4, 24'd4);
    send(24'd1); send(24'd2); send(24'd3);
    check("t1_no_early_valid", 32'(out_valid), 32'd0);
    send(24'd4);
    check("t1_valid_latency", 32'(out_valid), 32'd1);
    check("t1_in_ready_hold", 32'(in_ready), 32'd0);
    idle(1);
    check("t1_back_to_accum", 32'(in_ready), 32'd1);

    // 2: max values, no wrap
    push_exp(27'h3FFFFFC, 24'hFFFFFF, 24'hFFFFFF, 24'd0);
    for (int i = 0; i < 4; i++) send(24'hFFFFFF);
    idle(2);

    // 3: stall downstream for 5 cycles with in_valid pulsing
    out_ready = 1'b0;
    push_exp(27'd100, 24'd10, 24'd40, 24'd40);
    send(24'd10); send(24'd20); send(24'd30); send(24'd40);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 24'd999;
      @(negedge clk);
      check("t3_hold_valid",    32'(out_valid), 32'd1);
      check("t3_hold_in_ready", 32'(in_ready),  32'd0);
      check("t3_hold_sum",      32'(out_sum),   32'd100);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_gap_in_ready", 32'(in_ready), 32'd0);
    step();
    check("t3_ready_after_take", 32'(in_ready), 32'd1);
    check("t3_valid_after_take", 32'(out_valid), 32'd0);
    push_exp(27'd4, 24'd1, 24'd1, 24'd0);
    for (int i = 0; i < 4; i++) send(24'd1);
    idle(2);

    // 4: samples with idle gaps
    push_exp(27'd23, 24'd2, 24'd9, 24'd9);
    send(24'd9); idle(1); send(24'd5); idle(2); send(24'd7); send(24'd2);
    idle(2);

    // 5: clear discards a partial window
    send(24'd3); send(24'd4);
    clear = 1'b1;
    @(negedge clk);
    check("t5_clear_in_ready", 32'(in_ready), 32'd0);
    step();
    clear = 1'b0;
    push_exp(27'd26, 24'd5, 24'd8, 24'd12);
    send(24'd5); send(24'd6); send(24'd7); send(24'd8);
    idle(2);
    // clear while holding: record dropped, data registers retained
    out_ready = 1'b0;
    send(24'd100); send(24'd200); send(24'd300); send(24'd400);
    check("t5_hold_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clear_drops_valid", 32'(out_valid), 32'd0);
    check("t5_clear_keeps_sum",   32'(out_sum),   32'd1000);
    out_ready = 1'b1;
    idle(1);

    // 6a: async reset mid-window
    send(24'd50); send(24'd60);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_sum_async", 32'(out_sum),   32'd0);
    check("t6_rst_max_async", 32'(out_max),   32'd0);
    step();
    rst = 1'b0;
    push_exp(27'd50, 24'd11, 24'd14, 24'd4);
    send(24'd11); send(24'd12); send(24'd13);
    check("t6_no_stale_count", 32'(out_valid), 32'd0);
    send(24'd14);
    idle(2);

    // 6b: async reset mid-hold
    out_ready = 1'b0;
    send(24'd1); send(24'd2); send(24'd3); send(24'd4);
    check("t6_hold_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid_async", 32'(out_valid), 32'd0);
    check("t6_rst_xor_async",   32'(out_xor),   32'd0);
    check("t6_rst_min_async",   32'(out_min),   32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    push_exp(27'd20, 24'd2, 24'd8, 24'd8);
    send(24'd2); send(24'd4); send(24'd6);
    check("t6_need_full_window", 32'(out_valid), 32'd0);
    send(24'd8);
    check("t6_fresh_valid", 32'(out_valid), 32'd1);
    idle(3);

    check("records_drained", 32'(exp_q.size()), 32'd0);
    check("records_seen",    32'(n_popped),     32'd8);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
